// File: rtl/life_gen_sequencer.sv
// Game-of-Life generation sequencer for a 16x16 toroidal map in external row memory.
// A three-row sliding window (prev/cur/nxt) streams rows while results are written back in place.

module life_cell (
  input  logic [2:0] prev_w,
  input  logic [2:0] cur_w,
  input  logic [2:0] nxt_w,
  output logic       alive
);
  logic [3:0] cnt;

  assign cnt = 4'(prev_w[0]) + 4'(prev_w[1]) + 4'(prev_w[2]) +
               4'(cur_w[0])  + 4'(cur_w[2])  +
               4'(nxt_w[0])  + 4'(nxt_w[1])  + 4'(nxt_w[2]);
  assign alive = (cnt == 4'd3) || (cur_w[1] && (cnt == 4'd2));
endmodule

module life_gen_sequencer #(
  parameter int GEN_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_tick,
  input  logic                 run,
  input  logic                 edit_req,
  input  logic [3:0]           edit_x,
  input  logic [3:0]           edit_y,
  output logic                 edit_ack,
  output logic                 rd_en,
  output logic [3:0]           rd_addr,
  input  logic [15:0]          rd_data,
  output logic                 wr_en,
  output logic [3:0]           wr_addr,
  output logic [15:0]          wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [GEN_CNT_W-1:0] gen_count
);
  localparam int NUM_LANES = 16;

  typedef enum logic [3:0] {
    IDLE, PRIME0, PRIME1, PRIME2, PRIME3, GEN_WR, GEN_SH, EDIT_RD, EDIT_WR
  } state_t;

  state_t                 state, nxt_state;
  logic [NUM_LANES-1:0]   prev_q, cur_q, nxt_q, row0_save;
  logic [NUM_LANES-1:0]   next_row;
  logic [3:0]             row_q, ex_q, ey_q;
  logic                   armed_q;
  logic [GEN_CNT_W-1:0]   gen_q;

  // One cell evaluator per column; neighbours wrap around the torus.
  for (genvar x = 0; x < NUM_LANES; x++) begin : g_lane
    localparam int XL = (x + NUM_LANES - 1) % NUM_LANES;
    localparam int XR = (x + 1) % NUM_LANES;
    life_cell u_cell (
      .prev_w ({prev_q[XR], prev_q[x], prev_q[XL]}),
      .cur_w  ({cur_q[XR],  cur_q[x],  cur_q[XL]}),
      .nxt_w  ({nxt_q[XR],  nxt_q[x],  nxt_q[XL]}),
      .alive  (next_row[x])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (step_tick && run)     nxt_state = PRIME0;
               else if (edit_req && armed_q) nxt_state = EDIT_RD;
      PRIME0:  nxt_state = PRIME1;
      PRIME1:  nxt_state = PRIME2;
      PRIME2:  nxt_state = PRIME3;
      PRIME3:  nxt_state = GEN_WR;
      GEN_WR:  nxt_state = GEN_SH;
      GEN_SH:  nxt_state = (row_q == 4'd15) ? IDLE : GEN_WR;
      EDIT_RD: nxt_state = EDIT_WR;
      EDIT_WR: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    rd_en    = 1'b0;
    rd_addr  = 4'd0;
    wr_en    = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 16'd0;
    edit_ack = 1'b0;
    busy     = (state != IDLE);
    done     = (state == GEN_SH) && (row_q == 4'd15);
    case (state)
      PRIME0:  begin rd_en = 1'b1; rd_addr = 4'd15; end
      PRIME1:  begin rd_en = 1'b1; rd_addr = 4'd0;  end
      PRIME2:  begin rd_en = 1'b1; rd_addr = 4'd1;  end
      GEN_WR: begin
        wr_en   = 1'b1;
        wr_addr = row_q;
        wr_data = next_row;
        if (row_q <= 4'd13) begin
          rd_en   = 1'b1;
          rd_addr = row_q + 4'd2;
        end
      end
      EDIT_RD: begin rd_en = 1'b1; rd_addr = ey_q; end
      EDIT_WR: begin
        wr_en    = 1'b1;
        wr_addr  = ey_q;
        wr_data  = rd_data ^ (16'h0001 << ex_q);
        edit_ack = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= '0;
      cur_q     <= '0;
      nxt_q     <= '0;
      row0_save <= '0;
      row_q     <= 4'd0;
      ex_q      <= 4'd0;
      ey_q      <= 4'd0;
      armed_q   <= 1'b1;
      gen_q     <= '0;
    end else begin
      case (state)
        PRIME0: row_q <= 4'd0;
        PRIME1: prev_q <= rd_data;
        PRIME2: begin cur_q <= rd_data; row0_save <= rd_data; end
        PRIME3: nxt_q <= rd_data;
        GEN_SH: begin
          // Row 0 has already been overwritten, so the wrap uses the saved copy.
          prev_q <= cur_q;
          cur_q  <= nxt_q;
          if (row_q <= 4'd13)      nxt_q <= rd_data;
          else if (row_q == 4'd14) nxt_q <= row0_save;
          row_q <= row_q + 4'd1;
          if (row_q == 4'd15) gen_q <= gen_q + GEN_CNT_W'(1);
        end
        default: ;
      endcase
      if (state == IDLE && nxt_state == EDIT_RD) begin
        ex_q <= edit_x;
        ey_q <= edit_y;
      end
      // A held request toggles once; it must be seen low before re-arming.
      if (state == EDIT_WR) armed_q <= 1'b0;
      else if (!edit_req)   armed_q <= 1'b1;
    end
  end

  assign gen_count = gen_q;
endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed bench for life_gen_sequencer: behavioural row memory plus hand-computed map patterns.

module tb_life_gen_sequencer;
  logic        clk = 1'b0;
  logic        reset, step_tick, run, edit_req;
  logic [3:0]  edit_x, edit_y;
  logic        edit_ack, rd_en, wr_en, busy, done;
  logic [3:0]  rd_addr, wr_addr;
  logic [15:0] rd_data, wr_data, gen_count;

  life_gen_sequencer #(.GEN_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .step_tick(step_tick), .run(run),
    .edit_req(edit_req), .edit_x(edit_x), .edit_y(edit_y), .edit_ack(edit_ack),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];
  logic [15:0] init_rows [16];
  logic        do_load = 1'b0;

  always @(posedge clk) begin
    if (do_load) mem <= init_rows;
    else if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  int cyc = 0;
  int busy_cnt = 0, done_cnt = 0, ack_cnt = 0, bus_cnt = 0, done_cyc = 0, ack_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (edit_ack) begin ack_cnt++; ack_cyc = cyc; end
    if (rd_en || wr_en) bus_cnt++;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic load_map(input logic [15:0] r0, input int i0, input logic [15:0] r1, input int i1);
    @(negedge clk);
    for (int i = 0; i < 16; i++) init_rows[i] = 16'h0;
    init_rows[i0] = r0;
    init_rows[i1] = r1;
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0;
  endtask

  // Pulse step_tick for one cycle; t0 is the cycle in which it is sampled.
  task automatic tick(output int t0);
    @(negedge clk);
    step_tick = 1'b1;
    t0 = cyc;
    @(negedge clk);
    step_tick = 1'b0;
  endtask

  task automatic chk_map(input string tag, input logic [15:0] exp [16]);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_row%0d", tag, i), mem[i], exp[i]);
  endtask

  int t0, s, b0, d0, a0, bus0;
  logic [15:0] g0;
  logic [15:0] expm [16];

  initial begin
    reset = 1'b1; step_tick = 1'b0; run = 1'b1; edit_req = 1'b0;
    edit_x = 4'd0; edit_y = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_ack", edit_ack, 1'b0);
    chk("rst_gen", gen_count, 16'd0);
    reset = 1'b0;

    // Blinker: horizontal bar at row 7 becomes vertical at column 7.
    load_map(16'h01C0, 7, 16'h0, 0);
    b0 = busy_cnt; d0 = done_cnt;
    tick(t0);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 16; i++) expm[i] = 16'h0;
    expm[6] = 16'h0080; expm[7] = 16'h0080; expm[8] = 16'h0080;
    chk_map("blink", expm);
    chk("blink_busy", busy_cnt - b0, 36);
    chk("blink_done", done_cnt - d0, 1);
    chk("blink_done_lat", done_cyc - t0, 36);
    chk("blink_gen", gen_count, 16'd1);

    // Toroidal wrap in both directions.
    load_map(16'h8003, 0, 16'h0, 1);
    tick(t0);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 16; i++) expm[i] = 16'h0;
    expm[15] = 16'h0001; expm[0] = 16'h0001; expm[1] = 16'h0001;
    chk_map("wrap1", expm);
    tick(t0);
    repeat (40) @(negedge clk);
    chk("wrap2_row0", mem[0], 16'h8003);
    chk("wrap2_row1", mem[1], 16'h0000);
    chk("wrap2_row15", mem[15], 16'h0000);
    chk("wrap_gen", gen_count, 16'd3);

    // Held edit toggles exactly once; re-press toggles back.
    load_map(16'h0, 0, 16'h0, 1);
    a0 = ack_cnt;
    @(negedge clk);
    edit_x = 4'd3; edit_y = 4'd5; edit_req = 1'b1; s = cyc;
    repeat (20) @(negedge clk);
    edit_req = 1'b0;
    chk("edit_ack_once", ack_cnt - a0, 1);
    chk("edit_ack_lat", ack_cyc - s, 2);
    chk("edit_row5_set", mem[5], 16'h0008);
    repeat (3) @(negedge clk);
    edit_req = 1'b1;
    repeat (5) @(negedge clk);
    edit_req = 1'b0;
    chk("edit_ack_twice", ack_cnt - a0, 2);
    chk("edit_row5_clr", mem[5], 16'h0000);

    // Tick and edit together: generation first, edit right after.
    g0 = gen_count; d0 = done_cnt; a0 = ack_cnt;
    @(negedge clk);
    step_tick = 1'b1; edit_req = 1'b1; edit_x = 4'd0; edit_y = 4'd0; t0 = cyc;
    @(negedge clk);
    step_tick = 1'b0;
    repeat (45) @(negedge clk);
    edit_req = 1'b0;
    chk("sim_done", done_cnt - d0, 1);
    chk("sim_done_lat", done_cyc - t0, 36);
    chk("sim_ack", ack_cnt - a0, 1);
    chk("sim_ack_after_done", ack_cyc - done_cyc, 3);
    chk("sim_row0", mem[0], 16'h0001);
    chk("sim_gen", gen_count, g0 + 16'd1);

    // Tick ignored when not running.
    run = 1'b0;
    g0 = gen_count; bus0 = bus_cnt; b0 = busy_cnt;
    tick(t0);
    repeat (5) @(negedge clk);
    chk("norun_bus", bus_cnt - bus0, 0);
    chk("norun_busy", busy_cnt - b0, 0);
    chk("norun_gen", gen_count, g0);
    run = 1'b1;

    // Reset during GEN_WR of row 5, then a clean generation.
    load_map(16'h0030, 3, 16'h0030, 4);
    tick(t0);
    repeat (14) @(negedge clk);
    chk("mid_wr_en", wr_en, 1'b1);
    chk("mid_wr_addr", wr_addr, 4'd5);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_wr_en", wr_en, 1'b0);
    chk("mid_rst_gen", gen_count, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    b0 = busy_cnt; d0 = done_cnt;
    tick(t0);
    repeat (40) @(negedge clk);
    chk("post_busy", busy_cnt - b0, 36);
    chk("post_done", done_cnt - d0, 1);
    chk("post_gen", gen_count, 16'd1);
    for (int i = 0; i < 16; i++) expm[i] = 16'h0;
    expm[3] = 16'h0030; expm[4] = 16'h0030;
    chk_map("block", expm);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
